// File: rtl/line_follow_ctrl.sv
// Line-following steering controller: synchronises and debounces three IR sensors,
// then drives a steering FSM whose registered outputs command the two motors.
module line_follow_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LOST_TIMEOUT    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [1:0] l_mode,
    output logic [1:0] r_mode,
    output logic [2:0] state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LT_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LT_W-1:0] LOST_LAST = LT_W'(LOST_TIMEOUT - 1);

    localparam logic [1:0] M_STOP = 2'd0;
    localparam logic [1:0] M_FWD  = 2'd1;
    localparam logic [1:0] M_REV  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_LEFT  = 3'd2,
        S_RIGHT = 3'd3,
        S_LOST  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    typedef enum logic {
        TURN_LEFT  = 1'b0,
        TURN_RIGHT = 1'b1
    } turn_t;

    logic [2:0]      meta_q;
    logic [2:0]      sync_q;
    logic [2:0]      prev_q;
    logic [2:0]      filt_q;
    logic [2:0]      filt_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic [DB_W-1:0] db_next;
    logic [LT_W-1:0] lost_q;
    logic [LT_W-1:0] lost_d;
    state_t          state_q;
    state_t          state_d;
    turn_t           turn_q;
    turn_t           turn_d;
    logic [1:0]      l_mode_q;
    logic [1:0]      l_mode_d;
    logic [1:0]      r_mode_q;
    logic [1:0]      r_mode_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            meta_q   <= sensor;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // One shared counter: any change in the vector restarts the stability window.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        db_next  = (sync_q == prev_q) ? db_cnt_q + DB_W'(1) : '0;
        if (sync_q != filt_q) begin
            if (db_next == DB_LAST) begin
                filt_d = sync_q;
            end else begin
                db_cnt_d = db_next;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        lost_d  = '0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FWD;
                S_HALT: state_d = S_HALT;
                S_FWD, S_LEFT, S_RIGHT, S_LOST: begin
                    if (state_q == S_LOST && lost_q == LOST_LAST) begin
                        state_d = S_HALT;
                    end else begin
                        case (filt_q)
                            3'b010, 3'b111: state_d = S_FWD;
                            3'b100, 3'b110: begin
                                state_d = S_LEFT;
                                turn_d  = TURN_LEFT;
                            end
                            3'b001, 3'b011: begin
                                state_d = S_RIGHT;
                                turn_d  = TURN_RIGHT;
                            end
                            3'b000:  state_d = S_LOST;
                            default: state_d = state_q;
                        endcase
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_q == S_LOST && state_d == S_LOST) begin
            lost_d = lost_q + LT_W'(1);
        end

        // Modes follow the next state so they switch on the same edge as state.
        l_mode_d = M_STOP;
        r_mode_d = M_STOP;
        case (state_d)
            S_FWD: begin
                l_mode_d = M_FWD;
                r_mode_d = M_FWD;
            end
            S_LEFT: begin
                l_mode_d = M_STOP;
                r_mode_d = M_FWD;
            end
            S_RIGHT: begin
                l_mode_d = M_FWD;
                r_mode_d = M_STOP;
            end
            S_LOST: begin
                if (turn_d == TURN_LEFT) begin
                    l_mode_d = M_REV;
                    r_mode_d = M_FWD;
                end else begin
                    l_mode_d = M_FWD;
                    r_mode_d = M_REV;
                end
            end
            default: begin
                l_mode_d = M_STOP;
                r_mode_d = M_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            turn_q   <= TURN_LEFT;
            lost_q   <= '0;
            l_mode_q <= M_STOP;
            r_mode_q <= M_STOP;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            lost_q   <= lost_d;
            l_mode_q <= l_mode_d;
            r_mode_q <= r_mode_d;
        end
    end

    assign l_mode = l_mode_q;
    assign r_mode = r_mode_q;
    assign state  = state_q;

endmodule
